// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional build macro: DMEM_RESPONDER_PIPELINED_ACCEPT_EN (used in dmem_responder).
package dmem_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_BE_W   = 4;
    localparam int DMEM_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // One load/store request as presented on the request channel.
    typedef struct packed {
        logic                   we;
        logic [31:0]            addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [DMEM_BE_W-1:0]   be;
    } dmem_req_t;

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port synchronous word array with per-byte write enables and a
// registered read port. The read register only updates when rd_en is high,
// so it doubles as the response data holding register.
module dmem_sram_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [DMEM_BE_W-1:0]           wr_be,
    input  logic [DMEM_DATA_W-1:0]         wr_data,
    input  logic                           rd_en,
    output logic [DMEM_DATA_W-1:0]         rd_data
);

    logic [DMEM_DATA_W-1:0] mem [DEPTH_WORDS];

    // Byte-lane writes and enabled synchronous read on the shared address.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DMEM_BE_W; i++) begin
            if (wr_be[i]) begin
                mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the core's load/store port.
// One outstanding transaction, LATENCY wait cycles between accept and response.
// Optional build macro: DMEM_RESPONDER_PIPELINED_ACCEPT_EN -- when defined, a new
// request may be accepted on the same edge as the response handshake.
//
// Handshake rules: a request transfers on any rising edge where req_valid and
// req_ready are both high; a response transfers on any rising edge where
// rsp_valid and rsp_ready are both high. While rsp_valid is high and rsp_ready
// is low, rsp_rdata and rsp_err hold their values.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [31:0]            req_addr,
    input  logic [DMEM_DATA_W-1:0] req_wdata,
    input  logic [DMEM_BE_W-1:0]   req_be,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DMEM_DATA_W-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic                   busy
);

    localparam int                    AW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0]           SPAN    = 33'(DEPTH_WORDS) << 2;
    localparam logic [DMEM_CNT_W-1:0] LAT_CNT = DMEM_CNT_W'(LATENCY);
    localparam logic [DMEM_CNT_W-1:0] CNT_ONE = DMEM_CNT_W'(1);

    dmem_state_e            state_q, state_d;
    logic [DMEM_CNT_W-1:0]  cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic                   err_q, err_d;

    dmem_req_t              req_in;
    logic [31:0]            offset;
    logic                   addr_err;
    logic                   accept;
    logic [AW-1:0]          word_idx;
    logic [DMEM_BE_W-1:0]   arr_wr_be;
    logic                   arr_rd_en;
    logic [DMEM_DATA_W-1:0] arr_rd_data;

    assign req_in = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

    // Offset wraps to a huge value below BASE_ADDR, so one compare covers both bounds.
    assign offset   = req_in.addr - BASE_ADDR;
    assign addr_err = (req_in.addr[1:0] != 2'b00) || ({1'b0, offset} >= SPAN);
    assign word_idx = offset[AW+1:2];

`ifdef DMEM_RESPONDER_PIPELINED_ACCEPT_EN
    assign req_ready = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
`else
    assign req_ready = (state_q == IDLE);
`endif

    assign accept = req_valid && req_ready;

    // Stores commit on the accept edge; loads capture into the array read register.
    assign arr_wr_be = (accept && req_in.we && !addr_err) ? req_in.be : '0;
    assign arr_rd_en = accept && !req_in.we && !addr_err;

    dmem_sram_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .addr    (word_idx),
        .wr_be   (arr_wr_be),
        .wr_data (req_in.wdata),
        .rd_en   (arr_rd_en),
        .rd_data (arr_rd_data)
    );

    // State, wait counter and latched request attributes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; an accept overrides the per-state move.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: ;
            WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            we_d  = req_in.we;
            err_d = addr_err;
            cnt_d = LAT_CNT;
            if (LATENCY > 0) begin
                state_d = WAIT;
            end else begin
                state_d = RESP;
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? arr_rd_data : '0;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the core's load/store memory port, receiving MEM-stage requests and returning read data or write acknowledges.
- Valid/ready request channel and valid/ready response channel; one outstanding transaction.
- Programmable wait-state latency, so the pipeline's stall path can be exercised against slow memory.
- Contains the word-organised data array with byte-lane writes.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two.
- LATENCY, 2, extra wait cycles between request accept and response valid; range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous reset, active low
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, lane-aligned
- req_be  input  4  byte enables for stores; ignored for loads
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester consumes the response
- rsp_rdata  output  32  load data; 0 for stores and errors
- rsp_err  output  1  access fault
- busy  output  1  transaction in flight (state != IDLE)

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous and active-low.
  - On reset: state IDLE, wait counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - Array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept occurs on req_valid && req_ready.
  - On accept: latch we, addr, wdata, be; load counter with LATENCY.
  - Next state is WAIT if LATENCY>0, else RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; go to RESP when the counter reaches 1 on the current cycle.
- RESP:
  - rsp_valid=1, with rsp_rdata and rsp_err stable until rsp_valid && rsp_ready.
  - On that handshake: go to IDLE, and rsp_valid drops next cycle.
- Latency:
  - Accept at edge T gives rsp_valid high from cycle T+1+LATENCY.
  - Minimum round trip with LATENCY=0 and rsp_ready tied high is 2 cycles per access.
- Address check:
  - Error conditions: addr[1:0]!=0, or addr outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4).
  - On error: rsp_err=1, rsp_rdata=0, and no array write.
  - Word index = (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- Stores:
  - Committed on the accept edge, per byte lane where be[i]=1.
  - be=4'b0000 is legal: no change, normal response.
  - rsp_rdata=0.
- Loads:
  - The array is read synchronously; data is captured into rsp_rdata on entry to RESP.
  - Returns the full word; the requester extracts bytes and halfwords.
  - A load following a store to the same word returns the stored data.
- Back-pressure:
  - rsp_ready low holds RESP indefinitely; outputs are unchanged and no new request is accepted.
- Reset mid-operation:
  - Returns to IDLE and drops any pending response.
  - A store already accepted remains committed.
- req_wdata and req_be are don't-care while req_valid=0.

Optional Feature:
- Macro: DMEM_RESPONDER_PIPELINED_ACCEPT_EN.
- Defined:
  - In RESP, req_ready = rsp_ready.
  - A request arriving in the same cycle as the response handshake is accepted, and the block transitions directly to WAIT or RESP for the new request.
  - Sustains 1 access per cycle at LATENCY=0.
  - A store accepted on that edge commits before the next read capture.
- Undefined: req_ready is high only in IDLE, as specified above.

Decomposition:
- Package dmem_pkg:
  - state enum dmem_state_e {IDLE, WAIT, RESP}.
  - Constants: DMEM_DATA_W=32, DMEM_BE_W=4, DMEM_CNT_W=4.
  - Typedef dmem_req_t (we, addr, wdata, be) for the latched request.
- Sub-module dmem_sram_array:
  - Single-port synchronous array, DEPTH_WORDS x 32.
  - Per-byte write enables, registered read port.
- dmem_responder holds the FSM, counter, decode and response registers.

Test Plan:
- Reset with req_valid=1: req_ready=1, rsp_valid=0, rsp_err=0. Release reset; the request is accepted on the first edge.
- LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, be 4'hF, then load 0x10 → rsp_valid exactly 3 cycles after each accept; load rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte lanes: store 0x11223344 be 4'b0101 over 0xDEADBEEF at 0x10, then load 0x10 → 0xDE22BE44.
- Faults: load addr 0x12 → rsp_err=1, rdata=0. Store addr BASE_ADDR+DEPTH_WORDS*4 → rsp_err=1; a following load of word 0 is unchanged.
- Back-pressure: hold rsp_ready=0 for 5 cycles → rsp_valid, rsp_rdata and rsp_err stable; req_ready=0 throughout. Raise rsp_ready → IDLE next cycle.
- Reset asserted in WAIT after a store to 0x20 → outputs return to reset values asynchronously; a subsequent load of 0x20 returns the new data.
- With DMEM_RESPONDER_PIPELINED_ACCEPT_EN, LATENCY=0, rsp_ready=1: 8 back-to-back loads complete in 9 cycles.
